// File: rtl/hbus_responder.sv
// On-chip stand-in for the SDRAM controller host port: same busy/req handshake, backed by a small word RAM.
// Optional refresh emulation is built when HBUS_RESP_REFRESH_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_INIT    | post-reset wait, busy for INIT_CYCLES cycles
// ST_IDLE    | busy low, a command may be accepted
// ST_WRITE   | write stored at accept, busy for WRITE_LAT cycles
// ST_READ    | read in flight, data and strobe on the last cycle
// ST_REFRESH | (refresh build only) busy for 4 cycles
module hbus_responder #(
   parameter int MEM_AW      = 8,
   parameter int READ_LAT    = 3,
   parameter int WRITE_LAT   = 1,
   parameter int INIT_CYCLES = 16
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic [23:0] haddr,
   input  logic        hrw,
   input  logic        hrw_req,
   input  logic [15:0] hdata_in,
   output logic        busy,
   output logic [15:0] hdata_out,
   output logic        hdata_out_valid
);

   localparam int CNT_W = $clog2(INIT_CYCLES + 16);

`ifdef HBUS_RESP_REFRESH_EN
   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_REFRESH} state_t;
`else
   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ} state_t;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MEM_AW-1:0]   addr_q, addr_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [15:0]         rdata_q, rdata_d;
   logic                accept;
   logic                rd_done;
   logic                mem_we;
   logic [15:0]         mem [2**MEM_AW];

   // Upper host address bits alias onto the small RAM.
   logic haddr_unused;
   assign haddr_unused = ^haddr[23:MEM_AW];

`ifdef HBUS_RESP_REFRESH_EN
   logic [5:0] ref_cnt_q, ref_cnt_d;
   logic       ref_pend_q, ref_pend_d;
   logic       ref_due;
   logic       ref_start;

   assign ref_due   = (state_q != ST_INIT) && (ref_cnt_q == 6'd63);
   assign ref_start = (state_q == ST_IDLE) && ref_pend_q;
   assign ref_cnt_d = (state_q == ST_INIT) ? 6'd0 : ref_cnt_q + 6'd1;
   assign ref_pend_d = (ref_pend_q && !ref_start) || ref_due;
   assign accept    = hrw_req && (state_q == ST_IDLE) && !ref_pend_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_q  <= '0;
         ref_pend_q <= 1'b0;
      end else begin
         ref_cnt_q  <= ref_cnt_d;
         ref_pend_q <= ref_pend_d;
      end
   end
`else
   assign accept = hrw_req && (state_q == ST_IDLE);
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      case (state_q)
         ST_INIT: begin
            // Counts up from the reset value of zero to the terminal count.
            if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
`ifdef HBUS_RESP_REFRESH_EN
            if (ref_pend_q) begin
               state_d = ST_REFRESH;
               cnt_d   = CNT_W'(3);
            end else
`endif
            if (accept) begin
               addr_d  = haddr[MEM_AW-1:0];
               state_d = hrw ? ST_WRITE : ST_READ;
               cnt_d   = hrw ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
            end
         end
         default: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      busy_d  = (state_d != ST_IDLE);
      rd_done = (state_q == ST_READ) && (cnt_q == '0);
      valid_d = rd_done;
      rdata_d = rd_done ? mem[addr_q] : rdata_q;
      mem_we  = accept && hrw;
   end

   // RAM has no reset so contents survive a reset pulse.
   always_ff @(posedge sys_clk) begin
      if (mem_we) begin
         mem[haddr[MEM_AW-1:0]] <= hdata_in;
      end
   end

   assign busy            = busy_q;
   assign hdata_out       = rdata_q;
   assign hdata_out_valid = valid_q;

endmodule

// File: tb/tb_hbus_responder.sv
// Directed bench for hbus_responder: table of write/read vectors plus hand-written
// sequences for init, back-to-back spacing, mid-read reset and (optionally) refresh.
module tb_hbus_responder;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic [23:0] haddr   = '0;
   logic        hrw     = 1'b0;
   logic        hrw_req = 1'b0;
   logic [15:0] hdata_in = '0;
   logic        busy;
   logic [15:0] hdata_out;
   logic        hdata_out_valid;

   int total = 0;
   int bad   = 0;

   hbus_responder dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .haddr           (haddr),
      .hrw             (hrw),
      .hrw_req         (hrw_req),
      .hdata_in        (hdata_in),
      .busy            (busy),
      .hdata_out       (hdata_out),
      .hdata_out_valid (hdata_out_valid)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=%h exp=%h", name, act, exp);
      end
   endtask

   // Releases reset just after a rising edge and counts busy-high cycles.
   task automatic release_and_check_init();
      int   ones;
      logic clean;
      ones  = 0;
      clean = 1'b1;
      @(posedge sys_clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         if (hdata_out !== 16'h0000 || hdata_out_valid !== 1'b0) clean = 1'b0;
         if (busy === 1'b1) ones++;
         else break;
      end
      chk("init_busy_cycles", 32'(ones), 32'd16);
      chk("init_outputs_zero", 32'(clean), 32'd1);
   endtask

   // Issues one command at a falling edge; lat is edges from accept to
   // busy fall (write) or valid strobe (read).
   task automatic run_cmd(input logic rw, input logic [23:0] addr, input logic [15:0] wdata,
                          output int lat, output logic [15:0] data);
      int n;
      lat  = -1;
      data = 16'h0000;
      n    = 0;
      while (busy !== 1'b0 && n < 50) begin
         @(negedge sys_clk);
         n++;
      end
      hrw_req  = 1'b1;
      hrw      = rw;
      haddr    = addr;
      hdata_in = wdata;
      @(negedge sys_clk);
      hrw_req  = 1'b0;
      hdata_in = 16'hDEAD;
      haddr    = 24'h0;
      chk("accept_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge sys_clk);
         if (rw ? (busy === 1'b0) : (hdata_out_valid === 1'b1)) begin
            lat  = i;
            data = hdata_out;
            break;
         end
      end
      if (!rw) begin
         chk("rd_busy_fall", 32'(busy), 32'd0);
         @(negedge sys_clk);
         chk("rd_valid_one_cycle", 32'(hdata_out_valid), 32'd0);
      end
   endtask

   typedef struct {
      logic        rw;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int          lat;
      logic [15:0] data;
      logic [15:0] last_rd;
      int          acc_k[$];
      logic        acc_rw[$];
      logic [15:0] last_w;
      int          nacc;
      int          nvalid;
      logic        toggle;
      logic        no_strobe;
      int          ones;

      vecs[0] = '{1'b1, 24'h000005, 16'h00C3, 16'h0000};
      vecs[1] = '{1'b0, 24'h000005, 16'h0000, 16'h00C3};
      vecs[2] = '{1'b1, 24'h000105, 16'hBEEF, 16'h0000};
      vecs[3] = '{1'b0, 24'h000005, 16'h0000, 16'hBEEF};
      vecs[4] = '{1'b1, 24'hFFFF00, 16'h1234, 16'h0000};
      vecs[5] = '{1'b0, 24'h000000, 16'h0000, 16'h1234};
      vecs[6] = '{1'b1, 24'h0000FF, 16'hA5A5, 16'h0000};
      vecs[7] = '{1'b0, 24'hABCDFF, 16'h0000, 16'hA5A5};
      vecs[8] = '{1'b0, 24'h000105, 16'h0000, 16'hBEEF};

      repeat (3) @(negedge sys_clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_data", 32'(hdata_out), 32'h0);
      chk("rst_valid", 32'(hdata_out_valid), 32'd0);
      release_and_check_init();

`ifdef HBUS_RESP_REFRESH_EN
      // Refresh becomes pending 64 edges after init ends; request on that cycle.
      repeat (64) @(negedge sys_clk);
      hrw_req = 1'b1;
      hrw     = 1'b0;
      haddr   = 24'h000005;
      ones    = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (busy === 1'b1) ones++;
         else break;
      end
      chk("ref_busy_cycles", 32'(ones), 32'd4);
      @(negedge sys_clk);
      hrw_req = 1'b0;
      chk("ref_cmd_accepted", 32'(busy), 32'd1);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge sys_clk);
         if (hdata_out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      chk("ref_cmd_rd_lat", 32'(lat), 32'd3);
`endif

      last_rd = 16'h0000;
      for (int v = 0; v < 9; v++) begin
         run_cmd(vecs[v].rw, vecs[v].addr, vecs[v].wdata, lat, data);
         if (vecs[v].rw) begin
            chk($sformatf("wr_lat[%0d]", v), 32'(lat), 32'd1);
            chk($sformatf("wr_keeps_out[%0d]", v), 32'(data), 32'(last_rd));
         end else begin
            chk($sformatf("rd_lat[%0d]", v), 32'(lat), 32'd3);
            chk($sformatf("rd_data[%0d]", v), 32'(data), 32'(vecs[v].exp_data));
            last_rd = vecs[v].exp_data;
         end
      end

      // Back-to-back: request held high, direction alternates after each accept.
      hrw_req  = 1'b1;
      hrw      = 1'b1;
      haddr    = 24'h000010;
      hdata_in = 16'h5A00;
      last_w   = 16'h0000;
      nacc     = 0;
      nvalid   = 0;
      toggle   = 1'b0;
      for (int k = 0; k < 80 && nacc < 6; k++) begin
         if (hdata_out_valid === 1'b1) begin
            nvalid++;
            chk("b2b_rd_data", 32'(hdata_out), 32'(last_w));
         end
         if (busy === 1'b0) begin
            acc_k.push_back(k);
            acc_rw.push_back(hrw);
            if (hrw) last_w = hdata_in;
            nacc++;
            toggle = 1'b1;
         end
         @(negedge sys_clk);
         if (toggle) begin
            hrw      = ~hrw;
            hdata_in = hdata_in + 16'h0001;
            toggle   = 1'b0;
         end
      end
      hrw_req = 1'b0;
      chk("b2b_accepts", 32'(nacc), 32'd6);
      chk("b2b_valids", 32'(nvalid), 32'd2);
      for (int i = 1; i < acc_k.size(); i++) begin
         chk($sformatf("b2b_gap[%0d]", i), 32'(acc_k[i] - acc_k[i-1]), acc_rw[i-1] ? 32'd2 : 32'd4);
      end

      // Reset during a read, one edge after accept.
      for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge sys_clk);
      hrw_req = 1'b1;
      hrw     = 1'b0;
      haddr   = 24'h000005;
      @(negedge sys_clk);
      hrw_req = 1'b0;
      chk("abort_accept_busy", 32'(busy), 32'd1);
      @(negedge sys_clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd1);
      chk("abort_valid", 32'(hdata_out_valid), 32'd0);
      chk("abort_data_cleared", 32'(hdata_out), 32'h0);
      no_strobe = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         if (hdata_out_valid !== 1'b0) no_strobe = 1'b0;
      end
      chk("abort_no_strobe", 32'(no_strobe), 32'd1);
      release_and_check_init();
      run_cmd(1'b0, 24'h000005, 16'h0000, lat, data);
      chk("post_reset_rd_lat", 32'(lat), 32'd3);
      chk("post_reset_rd_data", 32'(data), 32'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hbus_responder.md
HBUS_RESPONDER -- requirements
Module: hbus_responder

Interface
REQ-001 The block SHALL provide parameter MEM_AW, default 8: memory address width; depth is 2^MEM_AW 16-bit words.
REQ-002 The block SHALL provide parameter READ_LAT, default 3, legal range 1..15: cycles from read accept to data.
REQ-003 The block SHALL provide parameter WRITE_LAT, default 1, legal range 1..15: busy cycles after write accept.
REQ-004 The block SHALL provide parameter INIT_CYCLES, default 16: busy cycles after reset release.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port haddr, input, 24 bits: host word address.
REQ-008 The block SHALL have port hrw, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port hrw_req, input, 1 bit: command valid.
REQ-010 The block SHALL have port hdata_in, input, 16 bits: write data.
REQ-011 The block SHALL have port busy, output, 1 bit: registered; the block does not accept commands while it is high.
REQ-012 The block SHALL have port hdata_out, output, 16 bits: read data.
REQ-013 The block SHALL have port hdata_out_valid, output, 1 bit: single-cycle strobe qualifying hdata_out.

Function
REQ-014 The block SHALL act as an on-chip stand-in responder for the SDRAM controller host interface, with identical handshake, for bring-up without SDRAM.
REQ-015 The block SHALL accept a command at a rising edge where hrw_req=1 and busy=0 (edge E0); haddr, hrw and hdata_in are sampled at E0.
REQ-016 The block SHALL ignore hrw_req while busy=1; the command is not consumed and no state changes.
REQ-017 The block SHALL implement the FSM states INIT, IDLE, WRITE, READ and (conditionally) REFRESH.
REQ-018 The FSM SHALL move INIT->IDLE after INIT_CYCLES cycles, IDLE->WRITE or IDLE->READ on accept, and WRITE/READ->IDLE on completion.
REQ-019 The block SHALL drive busy=0 only in IDLE.
REQ-020 On a write, the block SHALL store mem[haddr[MEM_AW-1:0]] <= hdata_in at E0.
REQ-021 On a write, busy SHALL be 1 after E0 through edge E(WRITE_LAT) and 0 after it.
REQ-022 On a read, the block SHALL load hdata_out from mem[haddr[MEM_AW-1:0]] and set hdata_out_valid=1 at edge E(READ_LAT); hdata_out_valid SHALL be 0 after E(READ_LAT+1).
REQ-023 On a read, busy SHALL fall at edge E(READ_LAT), so the earliest next accept is E(READ_LAT+1).
REQ-024 hdata_out SHALL hold its last read value until the next read completes; write commands SHALL NOT change it.
REQ-025 The block SHALL ignore haddr[23:MEM_AW]; such addresses alias.
REQ-026 A read of an address written earlier SHALL return the last written value.
REQ-027 A read accepted on the edge right after a write's busy falls SHALL return the new data.
REQ-028 Back-to-back commands with hrw_req held high SHALL be spaced by exactly WRITE_LAT+1 or READ_LAT+1 cycles.

Reset
REQ-029 While rst_n=0, the block SHALL hold busy=1, hdata_out=16'h0000, hdata_out_valid=0, the FSM in INIT, and all counters at 0.
REQ-030 An assertion of rst_n mid-operation SHALL abort the command, with no valid strobe and no further memory write.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 After rst_n deasserts, busy SHALL remain 1 for exactly INIT_CYCLES cycles.

Configuration
REQ-033 When HBUS_RESP_REFRESH_EN is defined, the block SHALL count 64 cycles per refresh request; a due refresh SHALL move IDLE->REFRESH for 4 busy cycles.
REQ-034 When HBUS_RESP_REFRESH_EN is defined, a refresh that comes due while a command is in flight SHALL stay pending until IDLE.
REQ-035 When HBUS_RESP_REFRESH_EN is defined, a refresh and hrw_req in the same IDLE cycle SHALL resolve in favour of the refresh, with the command held off.
REQ-036 When HBUS_RESP_REFRESH_EN is undefined, the REFRESH state and its counter SHALL be absent and busy SHALL depend only on INIT/WRITE/READ.

Verification (defaults, refresh disabled unless stated)
REQ-037 The bench SHALL cover: release reset -> busy=1 for 16 cycles then 0; hdata_out=0 and hdata_out_valid=0 throughout.
REQ-038 The bench SHALL cover: write 0x00C3 to haddr 0x000005, then read 0x000005 -> hdata_out_valid exactly 3 edges after read accept, hdata_out=0x00C3.
REQ-039 The bench SHALL cover: write 0xBEEF to haddr 0x000105 (aliases 0x05), read 0x000005 -> 0xBEEF.
REQ-040 The bench SHALL cover: hrw_req held high with alternating write/read -> accepts spaced 2 and 4 cycles; no accept while busy=1.
REQ-041 The bench SHALL cover: assert rst_n during READ before E3 -> no valid pulse, busy=1, 16-cycle init; memory still returns 0xBEEF afterwards.
REQ-042 The bench SHALL cover, with HBUS_RESP_REFRESH_EN defined: hrw_req asserted on the refresh-due cycle -> busy=1 for 4 cycles, then the command is accepted.
